// File: rtl/alarme_ctrl.sv
// Clocked K-of-N alarm controller: per-channel sensor debounce, registered vote count,
// arm/disarm control, entry-delay countdown, time-limited siren and a latched trip mask.
module alarme_ctrl #(
    parameter int unsigned N_SENSORS    = 3,
    parameter int unsigned VOTE         = 2,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned ENTRY_DELAY  = 8,
    parameter int unsigned SIREN_CYCLES = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           arm_i,
    input  logic                           disarm_i,
    input  logic [N_SENSORS-1:0]           sensors_i,
    output logic                           armed_o,
    output logic                           pending_o,
    output logic                           siren_o,
    output logic                           tripped_o,
    output logic [N_SENSORS-1:0]           trip_mask_o,
    output logic [$clog2(N_SENSORS+1)-1:0] active_cnt_o
);

    localparam int unsigned CntW = $clog2(N_SENSORS + 1);
    localparam int unsigned DbW  = $clog2(DEBOUNCE + 1);
    // Keep the delay counter at least one bit wide even when the entry delay is disabled.
    localparam int unsigned DlyW = (ENTRY_DELAY > 0) ? $clog2(ENTRY_DELAY + 1) : 1;
    localparam int unsigned SirW = $clog2(SIREN_CYCLES + 1);

    localparam logic [DbW-1:0]  DbMax   = DbW'(DEBOUNCE);
    localparam logic [DlyW-1:0] DlyLoad = DlyW'((ENTRY_DELAY > 0) ? (ENTRY_DELAY - 1) : 0);
    localparam logic [SirW-1:0] SirLoad = SirW'(SIREN_CYCLES - 1);
    localparam logic [CntW-1:0] VoteThr = CntW'(VOTE);

    typedef enum logic [2:0] {
        StDisarmed,
        StArmed,
        StPending,
        StAlarm,
        StTripped
    } state_e;

    state_e                state_q, state_d;
    logic [DbW-1:0]        db_cnt_q [N_SENSORS];
    logic [DbW-1:0]        db_cnt_d [N_SENSORS];
    logic [N_SENSORS-1:0]  deb_active;
    logic [CntW-1:0]       active_cnt_q, active_cnt_d;
    logic [DlyW-1:0]       dly_q, dly_d;
    logic [SirW-1:0]       sir_q, sir_d;
    logic [N_SENSORS-1:0]  mask_q, mask_d;
    logic                  armed_q, pending_q, siren_q, tripped_q;
    logic                  vote_hit;

    // Per-channel debounce: count consecutive high cycles, saturate, clear on any low cycle.
    always_comb begin
        for (int i = 0; i < N_SENSORS; i++) begin
            db_cnt_d[i] = '0;
            if (sensors_i[i]) begin
                db_cnt_d[i] = (db_cnt_q[i] == DbMax) ? db_cnt_q[i] : db_cnt_q[i] + DbW'(1);
            end
            deb_active[i] = (db_cnt_q[i] == DbMax);
        end
    end

    // Popcount of the debounced-active vector, registered before it feeds the vote.
    always_comb begin
        active_cnt_d = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            active_cnt_d = active_cnt_d + CntW'(deb_active[i]);
        end
    end

    assign vote_hit = (active_cnt_q >= VoteThr);

    // Next-state logic; disarm overrides every state and clears all trip bookkeeping.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        sir_d   = sir_q;
        mask_d  = mask_q;
        if (disarm_i) begin
            state_d = StDisarmed;
            dly_d   = '0;
            sir_d   = '0;
            mask_d  = '0;
        end else begin
            unique case (state_q)
                StDisarmed: begin
                    // Refuse to arm while any sensor is already active.
                    if (arm_i && (active_cnt_q == '0)) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (vote_hit) begin
                        mask_d = deb_active;
                        if (ENTRY_DELAY == 0) begin
                            state_d = StAlarm;
                            sir_d   = SirLoad;
                        end else begin
                            state_d = StPending;
                            dly_d   = DlyLoad;
                        end
                    end
                end
                StPending: begin
                    if (dly_q == '0) begin
                        state_d = StAlarm;
                        sir_d   = SirLoad;
                    end else begin
                        dly_d = dly_q - DlyW'(1);
                    end
                end
                StAlarm: begin
                    if (sir_q == '0) begin
                        state_d = StTripped;
                    end else begin
                        sir_d = sir_q - SirW'(1);
                    end
                end
                StTripped: begin
                    state_d = StTripped;
                end
                default: begin
                    state_d = StDisarmed;
                end
            endcase
        end
    end

    // State, counters and registered outputs; outputs decode the next state so they
    // reflect the state entered on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StDisarmed;
            for (int i = 0; i < N_SENSORS; i++) begin
                db_cnt_q[i] <= '0;
            end
            active_cnt_q <= '0;
            dly_q        <= '0;
            sir_q        <= '0;
            mask_q       <= '0;
            armed_q      <= 1'b0;
            pending_q    <= 1'b0;
            siren_q      <= 1'b0;
            tripped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < N_SENSORS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            active_cnt_q <= active_cnt_d;
            dly_q        <= dly_d;
            sir_q        <= sir_d;
            mask_q       <= mask_d;
            armed_q      <= (state_d != StDisarmed);
            pending_q    <= (state_d == StPending);
            siren_q      <= (state_d == StAlarm);
            tripped_q    <= (state_d == StTripped);
        end
    end

    assign armed_o      = armed_q;
    assign pending_o    = pending_q;
    assign siren_o      = siren_q;
    assign tripped_o    = tripped_q;
    assign trip_mask_o  = mask_q;
    assign active_cnt_o = active_cnt_q;

endmodule

// File: doc/alarme_ctrl.md
# alarme_ctrl

Parametrised, clocked alarm controller: N sensor channels with per-channel debounce, a configurable K-of-N vote, arm/disarm control, an entry-delay countdown, a time-limited siren output and a latched record of which sensors tripped. It extends the combinational alarm function into a sequential block that sits between the raw sensor pins and the siren/indicator outputs on the FPGA board.

## Interface
- N_SENSORS, 3: number of sensor channels (1..16).
- VOTE, 2: number of debounced-active sensors that triggers an alarm (1..N_SENSORS).
- DEBOUNCE, 4: consecutive cycles a raw sensor must be high before it counts as active (≥1).
- ENTRY_DELAY, 8: cycles spent in PENDING before the siren starts (0 = immediate).
- SIREN_CYCLES, 16: cycles the siren stays on (≥1).

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  level; request to arm.
- disarm  in  1  level; request to disarm, has priority over everything except rst.
- sensors  in  N_SENSORS  raw sensor inputs, already synchronised to clk.
- armed  out  1  high in ARMED, PENDING, ALARM, TRIPPED.
- pending  out  1  high only in PENDING.
- siren  out  1  high only in ALARM.
- tripped  out  1  high only in TRIPPED.
- trip_mask  out  N_SENSORS  debounced sensors that were active when the vote fired, latched.
- active_cnt  out  $clog2(N_SENSORS+1)  current count of debounced-active sensors.

## Operation
- Debounce per channel: counter increments while raw bit high, saturates at DEBOUNCE; any low cycle clears counter to 0. Channel debounced-active when counter == DEBOUNCE. Debounce runs in every state.
- active_cnt = popcount of debounced-active vector, registered. vote_hit = (active_cnt ≥ VOTE), using the registered value.
- States: DISARMED, ARMED, PENDING, ALARM, TRIPPED.
- DISARMED: arm=1, disarm=0 and active_cnt == 0 → ARMED. Arm while any sensor debounced-active is ignored (stay DISARMED).
- ARMED: vote_hit → PENDING (or ALARM directly if ENTRY_DELAY == 0); trip_mask loads the debounced-active vector on that same transition.
- PENDING: delay counter loads ENTRY_DELAY−1 on entry, decrements each cycle; at 0 → ALARM. Sensors going inactive do not cancel PENDING.
- ALARM: siren counter loads SIREN_CYCLES−1 on entry, decrements; at 0 → TRIPPED. A new vote_hit does not retrigger the siren.
- TRIPPED: stays until disarm; arm ignored.
- disarm=1 in any state → DISARMED next cycle; trip_mask cleared to 0; delay and siren counters cleared. disarm and arm both high → disarm wins.
- trip_mask holds its value through PENDING, ALARM, TRIPPED; changes only on load or disarm/reset.

## Timing
- Reset (rst=1 on a clock edge): state DISARMED, all debounce counters 0, armed=0, pending=0, siren=0, tripped=0, trip_mask=0, active_cnt=0. Reset mid-operation aborts immediately, no partial state retained.
- All outputs registered; state-derived outputs valid the cycle after the transition edge.
- Sensor-to-alarm latency, ENTRY_DELAY>0: raw rise at edge t → debounced at t+DEBOUNCE → active_cnt at t+DEBOUNCE+1 → PENDING at t+DEBOUNCE+2 → siren high at t+DEBOUNCE+2+ENTRY_DELAY.
- ENTRY_DELAY == 0: siren high at t+DEBOUNCE+2, pending never asserted.
- Siren high for exactly SIREN_CYCLES cycles, then tripped high the next cycle.
- arm → armed: 1 cycle. disarm → armed/siren/tripped low: 1 cycle.
- Counters sized $clog2(max+1); no wrap-around: debounce saturates, delay/siren counters stop at 0 on exit.

## Test plan
- Reset: drive sensors=3'b111, arm=1, rst=1 for 3 cycles → all outputs 0, active_cnt=0; release rst with arm=0 → stays DISARMED.
- Debounce glitch: armed, sensors[0] and [1] high 3 cycles then low (DEBOUNCE=4) → active_cnt stays 0, no PENDING.
- Vote trip: armed, sensors=3'b011 held → pending high at +6 for 8 cycles, siren high 16 cycles, then tripped=1, trip_mask=3'b011.
- Single sensor below vote: armed, sensors=3'b100 held 50 cycles → active_cnt=1, state stays ARMED, siren=0.
- Disarm mid-PENDING and arm+disarm together → DISARMED next cycle, trip_mask=0, siren never asserts.
- Arm blocked: sensors=3'b001 debounced, arm=1 → armed stays 0; drop sensor, arm=1 → armed=1 one cycle later.
